// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the data memory controller and its storage array.
// Provides the controller state encoding, the byte-lane width and the lane parity function.
// Optional per-lane parity is enabled by defining DATA_MEM_PARITY_EN.
package data_mem_pkg;

  localparam int LANE_W = 8;

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_e;

  // Even parity: the stored bit makes the total count of ones in lane+bit even.
  function automatic logic lane_parity(input logic [LANE_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Purpose: DEPTH x DATA_W storage with one byte-lane-masked write port and one combinational read port.
// Latency: writes land at the clock edge; reads are combinational from rd_addr.
// Backpressure: none; the controller decides when to write and when to sample rd_data.
// Ports: clk; wr_en/wr_addr/wr_be/wr_data write port; rd_addr/rd_data read port;
//        rd_par (per-lane stored parity) only when DATA_MEM_PARITY_EN is defined.
module data_mem_array
  import data_mem_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W/LANE_W-1:0] wr_be,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        rd_data
`ifdef DATA_MEM_PARITY_EN
  ,
  output logic [DATA_W/LANE_W-1:0] rd_par
`endif
);

  localparam int NB    = DATA_W / LANE_W;
  localparam int DEPTH = 1 << ADDR_W;

  // Storage is not reset; the controller's clear sequence zeroes it.
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) mem_q[wr_addr][i*LANE_W +: LANE_W] <= wr_data[i*LANE_W +: LANE_W];
      end
    end
  end

  assign rd_data = mem_q[rd_addr];

`ifdef DATA_MEM_PARITY_EN
  logic [NB-1:0] par_q [DEPTH];

  // Parity travels with its lane so a partial write never leaves a stale parity bit.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) par_q[wr_addr][i] <= lane_parity(wr_data[i*LANE_W +: LANE_W]);
      end
    end
  end

  assign rd_par = par_q[rd_addr];
`endif

endmodule

// File: rtl/data_mem_ctrl.sv
// Purpose: data memory controller with valid/ready requests, byte-lane writes and a zero-clear sequencer.
// Latency: read data appears one cycle after acceptance; clear takes DEPTH cycles after reset or clear_req.
// Backpressure: a held response (rsp_valid & !rsp_ready) freezes rsp_* and drops req_ready.
// Ports: clk, reset (sync, active-high); req_valid/req_ready/req_we/req_addr/req_be/req_wdata request;
//        rsp_valid/rsp_ready/rsp_data response; clear_req/busy clear control;
//        rsp_perr only when DATA_MEM_PARITY_EN is defined.
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W/LANE_W-1:0] req_be,
  input  logic [DATA_W-1:0]        req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_data,
  input  logic                     clear_req,
  output logic                     busy
`ifdef DATA_MEM_PARITY_EN
  ,
  output logic                     rsp_perr
`endif
);

  localparam int NB    = DATA_W / LANE_W;
  localparam int DEPTH = 1 << ADDR_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              busy_q, busy_d;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [NB-1:0]     wr_be;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              rd_perr;

`ifdef DATA_MEM_PARITY_EN
  logic [NB-1:0] rd_par;
  logic          rsp_perr_q, rsp_perr_d;

  always_comb begin
    rd_perr = 1'b0;
    for (int i = 0; i < NB; i++) begin
      rd_perr |= lane_parity(rd_data[i*LANE_W +: LANE_W]) ^ rd_par[i];
    end
  end
`else
  assign rd_perr = 1'b0;
`endif

  data_mem_array #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_be  (wr_be),
    .wr_data(wr_data),
    .rd_addr(req_addr),
    .rd_data(rd_data)
`ifdef DATA_MEM_PARITY_EN
    ,
    .rd_par (rd_par)
`endif
  );

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    busy_d      = busy_q;
    req_ready   = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = req_addr;
    wr_be       = req_be;
    wr_data     = req_wdata;
`ifdef DATA_MEM_PARITY_EN
    rsp_perr_d  = rsp_perr_q;
`endif

    // A consumed response retires unless a new read below reloads it.
    if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        wr_en      = 1'b1;
        wr_addr    = clr_addr_q;
        wr_be      = '1;
        wr_data    = '0;
        clr_addr_d = clr_addr_q + ADDR_W'(1);
        if (clr_addr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      ST_IDLE: begin
        // clear_req masks acceptance so it wins over a same-cycle request.
        req_ready = (!rsp_valid_q || rsp_ready) && !clear_req;
        if (req_valid && req_ready) begin
          if (req_we) begin
            wr_en = 1'b1;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = rd_data;
`ifdef DATA_MEM_PARITY_EN
            rsp_perr_d  = rd_perr;
`endif
          end
        end
        // A pending response (even one being consumed now) blocks the clear.
        if (clear_req && !rsp_valid_q) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
          busy_d     = 1'b1;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_CLEAR;
      clr_addr_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b1;
`ifdef DATA_MEM_PARITY_EN
      rsp_perr_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
`ifdef DATA_MEM_PARITY_EN
      rsp_perr_q  <= rsp_perr_d;
`endif
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;
`ifdef DATA_MEM_PARITY_EN
  assign rsp_perr  = rsp_perr_q;
`else
  // Parity is absent in this build; keep the tie-off visibly consumed.
  logic unused_perr;
  assign unused_perr = rd_perr;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
`timescale 1ns/1ps
module tb_data_mem_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 2;
  localparam int NB     = DATA_W / 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [NB-1:0]     req_be;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              clear_req;
  logic              busy;
`ifdef DATA_MEM_PARITY_EN
  logic              rsp_perr;
  logic [NB-1:0]     bad_m [DEPTH];
  bit                perr_q [$];
`endif

  int checks   = 0;
  int failures = 0;
  bit rnd_bp   = 1'b0;

  logic [DATA_W-1:0] model [DEPTH];
  logic [DATA_W-1:0] exp_q [$];

  always #5 clk = ~clk;

  data_mem_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_be   (req_be),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .clear_req(clear_req),
    .busy     (busy)
`ifdef DATA_MEM_PARITY_EN
    ,
    .rsp_perr (rsp_perr)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference memory: after reset or clear every word reads zero.
  task automatic model_zero();
    for (int i = 0; i < DEPTH; i++) begin
      model[i] = '0;
`ifdef DATA_MEM_PARITY_EN
      bad_m[i] = '0;
`endif
    end
  endtask

  // Scoreboard monitor: every delivered response is matched against the queue head.
  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected: got data 0x%0h with no read outstanding", rsp_data);
      end else begin
        chk("rsp_data", rsp_data, exp_q.pop_front());
`ifdef DATA_MEM_PARITY_EN
        chk("rsp_perr", rsp_perr, perr_q.pop_front());
`endif
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one request starting at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input bit we, input logic [ADDR_W-1:0] a, input logic [NB-1:0] be,
                       input logic [DATA_W-1:0] d);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_be    = be;
    req_wdata = d;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(posedge clk);
      #1;
      if (rnd_bp) rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: req_ready stayed 0 for %0d cycles, required 1", n);
    end else if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          model[a][i*8 +: 8] = d[i*8 +: 8];
`ifdef DATA_MEM_PARITY_EN
          bad_m[a][i] = 1'b0;
`endif
        end
      end
    end else begin
      exp_q.push_back(model[a]);
`ifdef DATA_MEM_PARITY_EN
      perr_q.push_back(|bad_m[a]);
`endif
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (rnd_bp) rsp_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Call at posedge+1 right after the edge that starts a clear; returns at posedge+1.
  task automatic check_clear_window(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_req_ready"}, req_ready, 0);
    end
    @(negedge clk);
    chk({tag, "_busy_done"}, busy, 0);
    chk({tag, "_req_ready_done"}, req_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) issue(1'b0, ADDR_W'(i), '0, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_be    = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    clear_req = 1'b0;

    // Reset values, then the post-reset clear window.
    @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_zero();
    check_clear_window("reset");
    read_all();

    // Basic read/write with explicit one-cycle response latency.
    issue(1'b1, 2'd1, '1, 32'h3C);
    issue(1'b0, 2'd1, '0, '0);
    @(negedge clk);
    chk("lat_rsp_valid", rsp_valid, 1);
    chk("lat_rsp_data", rsp_data, 32'h3C);
    @(posedge clk);
    #1;
    issue(1'b1, 2'd3, '1, 32'hF0);
    issue(1'b0, 2'd3, '0, '0);
    issue(1'b0, 2'd1, '0, '0);

    // Byte lanes, including a be=0 write that must not change anything.
    issue(1'b1, 2'd2, 4'hF, 32'hDEADBEEF);
    issue(1'b1, 2'd2, 4'b0101, 32'h11223344);
    issue(1'b0, 2'd2, '0, '0);
    issue(1'b1, 2'd2, 4'h0, 32'hFFFFFFFF);
    issue(1'b0, 2'd2, '0, '0);

    // Backpressure: first response held five cycles, then two back-to-back deliveries.
    idle(2);
    rsp_ready = 1'b0;
    issue(1'b0, 2'd1, '0, '0);
    fork
      issue(1'b0, 2'd3, '0, '0);
      begin
        repeat (5) begin
          @(negedge clk);
          chk("bp_rsp_valid", rsp_valid, 1);
          chk("bp_rsp_data", rsp_data, model[1]);
          chk("bp_req_ready", req_ready, 0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
      end
    join
    @(negedge clk);
    chk("bp_second_valid", rsp_valid, 1);
    chk("bp_second_data", rsp_data, model[3]);
    @(posedge clk);
    #1;

    // clear_req while a response is pending is ignored.
    idle(2);
    rsp_ready = 1'b0;
    issue(1'b0, 2'd3, '0, '0);
    clear_req = 1'b1;
    @(posedge clk);
    #1;
    clear_req = 1'b0;
    @(negedge clk);
    chk("clr_pending_busy", busy, 0);
    chk("clr_pending_rsp_valid", rsp_valid, 1);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    idle(2);
    read_all();

    // clear_req wins over a simultaneous write.
    idle(2);
    clear_req = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 2'd0;
    req_be    = '1;
    req_wdata = 32'hA5A5A5A5;
    @(negedge clk);
    chk("clr_prio_req_ready", req_ready, 0);
    @(posedge clk);
    #1;
    clear_req = 1'b0;
    req_valid = 1'b0;
    model_zero();
    check_clear_window("clear");
    read_all();

    // Reset two cycles into a clear restarts it from address 0.
    issue(1'b1, 2'd2, '1, 32'h12345678);
    idle(1);
    clear_req = 1'b1;
    @(posedge clk);
    #1;
    clear_req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_zero();
    check_clear_window("rst_mid_clear");
    read_all();

`ifdef DATA_MEM_PARITY_EN
    issue(1'b1, 2'd1, '1, 32'h3C);
    dut.u_array.par_q[1][0] = ~dut.u_array.par_q[1][0];
    bad_m[1][0] = 1'b1;
    issue(1'b0, 2'd1, '0, '0);
    issue(1'b0, 2'd0, '0, '0);
    issue(1'b1, 2'd1, '1, 32'h3C);
`endif

    // Randomised traffic with random response backpressure.
    rnd_bp = 1'b1;
    repeat (300) begin
      issue(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, DEPTH - 1)),
            NB'($urandom), DATA_W'($urandom));
    end
    rnd_bp = 1'b0;
    rsp_ready = 1'b1;
    idle(4);
    chk("drain_outstanding", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
